// File: rtl/vedic_mul_arbiter.sv
// vedic_mul_arbiter: shares one pipelined 32x32 multiplier among N_REQ requesters.
//   Round-robin combinational grant, registered issue stage, {vld,id} tag
//   pipeline aligned to the multiplier depth, tagged broadcast of products.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot)
//   req_a/req_b           operand pairs, requester i at [32*i +: 32]
//   rsp_valid/rsp_id/rsp_p  product pulse, requester id, 64-bit product
//   busy                  any op in flight
// Optional: define MUL_ARB_PERF_CNT_EN to add perf_issue / perf_stall counters.

// simple_vedic_32bit: 32x32 unsigned multiplier, fixed LATENCY (>= 2), no stall.
//   Stage 1 forms four 16x16 partial products, stage 2 combines them, the
//   remaining stages only delay the result.
module simple_vedic_32bit #(
  parameter int unsigned LATENCY = 5
) (
  input  logic        clk,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] s
);

  logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic [32:0] cross_c;
  logic [63:0] sum_c;
  logic [63:0] s_pipe [LATENCY-1];

  // Vertical/crosswise partial products
  always_ff @(posedge clk) begin
    pp_ll <= 32'(a[15:0])  * 32'(b[15:0]);
    pp_lh <= 32'(a[15:0])  * 32'(b[31:16]);
    pp_hl <= 32'(a[31:16]) * 32'(b[15:0]);
    pp_hh <= 32'(a[31:16]) * 32'(b[31:16]);
  end

  always_comb begin
    cross_c = 33'(pp_lh) + 33'(pp_hl);
    sum_c   = {pp_hh, pp_ll} + (64'(cross_c) << 16);
  end

  // Combine stage followed by pure delay stages
  always_ff @(posedge clk) begin
    s_pipe[0] <= sum_c;
    for (int i = 1; i < int'(LATENCY) - 1; i++) begin
      s_pipe[i] <= s_pipe[i-1];
    end
  end

  assign s = s_pipe[LATENCY-2];

endmodule

module vedic_mul_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned MUL_LATENCY = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_p,
  output logic                  busy
`ifdef MUL_ARB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_issue,
  output logic [31:0]           perf_stall
`endif
);

  localparam int unsigned OP_W = 32;

  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [N_REQ-1:0] lower_mask, high_req, pick, onehot;
  logic             hs;
  logic [ID_W-1:0]  gid;
  logic [OP_W-1:0]  grant_a, grant_b;
  logic [OP_W-1:0]  op_a, op_b;
  logic [63:0]      mul_s;

  logic [MUL_LATENCY:0]           tag_vld;
  logic [MUL_LATENCY:0][ID_W-1:0] tag_id;

  logic [N_REQ:0][ID_W-1:0] id_chain;
  logic [N_REQ:0][OP_W-1:0] a_chain, b_chain;

  // Round-robin pick: requests at or above rr_ptr first, else wrap to the lowest
  always_comb begin
    lower_mask = (N_REQ'(1) << rr_ptr) - N_REQ'(1);
    high_req   = req_valid & ~lower_mask;
    pick       = (|high_req) ? high_req : req_valid;
    onehot     = pick & (~pick + N_REQ'(1));
    req_ready  = rst ? '0 : onehot;
    hs         = |req_ready;
  end

  // AND-OR mux of the granted id and operands
  assign id_chain[0] = '0;
  assign a_chain[0]  = '0;
  assign b_chain[0]  = '0;
  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_mux
    assign id_chain[g+1] = id_chain[g] | (onehot[g] ? ID_W'(g) : '0);
    assign a_chain[g+1]  = a_chain[g]  | (onehot[g] ? req_a[OP_W*g +: OP_W] : '0);
    assign b_chain[g+1]  = b_chain[g]  | (onehot[g] ? req_b[OP_W*g +: OP_W] : '0);
  end
  assign gid     = id_chain[N_REQ];
  assign grant_a = a_chain[N_REQ];
  assign grant_b = b_chain[N_REQ];

  // Pointer advances past the winner; holds when idle
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (hs) begin
      rr_ptr_nxt = (32'(gid) + 32'd1 == N_REQ) ? '0 : gid + ID_W'(1);
    end
  end

  // Issue register zeroes the operands on idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
      op_a   <= hs ? grant_a : '0;
      op_b   <= hs ? grant_b : '0;
    end
  end

  // Tag pipeline: stage 0 is the issue stage, last stage lines up with mul_s
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[MUL_LATENCY-1:0], hs};
      tag_id  <= {tag_id[MUL_LATENCY-1:0], gid};
    end
  end

  simple_vedic_32bit #(
    .LATENCY (MUL_LATENCY)
  ) u_mul (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .s   (mul_s)
  );

  // Gated by rst so nothing is broadcast while reset is asserted
  assign rsp_valid = tag_vld[MUL_LATENCY] & ~rst;
  assign rsp_id    = tag_id[MUL_LATENCY];
  assign rsp_p     = mul_s;
  assign busy      = |tag_vld;

`ifdef MUL_ARB_PERF_CNT_EN
  // Stall = at least two requesters competing in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (hs) perf_issue <= perf_issue + 32'd1;
      if ((req_valid & (req_valid - N_REQ'(1))) != '0) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// tb_vedic_mul_arbiter: directed bench for vedic_mul_arbiter with a product
// scoreboard (expected a*b pushed on each handshake, popped on rsp_valid).
module tb_vedic_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_p;
  logic         busy;
`ifdef MUL_ARB_PERF_CNT_EN
  logic [31:0]  perf_issue, perf_stall;
  logic [31:0]  pi0, ps0;
`endif

  vedic_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LATENCY(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
`ifdef MUL_ARB_PERF_CNT_EN
    ,
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] p;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rsp_cnt = 0;
  int          first_rsp_cyc = 0;
  int          last_rsp_cyc = 0;
  bit          mark_first = 1'b0;
  logic [63:0] last_p = '0;
  logic [1:0]  last_id = '0;
  int          base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() != 0; k++) @(negedge clk);
    check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard push on handshake, pop/compare on rsp_valid
  always @(negedge clk) begin
    if (rst) begin
      check("ready_in_rst", 64'(req_ready), 64'd0);
      check("rsp_in_rst", 64'(rsp_valid), 64'd0);
      q.delete();
    end else begin
      check("ready_subset", 64'(req_ready & ~req_valid), 64'd0);
      check("ready_onehot", 64'((req_ready & (req_ready - 4'd1)) != 4'd0), 64'd0);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_p", rsp_p, e.p);
          check("rsp_latency", 64'(cyc - e.cyc), 64'd6);
        end
        rsp_cnt++;
        if (mark_first) begin
          first_rsp_cyc = cyc;
          mark_first = 1'b0;
        end
        last_rsp_cyc = cyc;
        last_p = rsp_p;
        last_id = rsp_id;
      end
      for (int j = 0; j < 4; j++) begin
        if (req_valid[j] && req_ready[j]) begin
          q.push_back('{id: 2'(j),
                        p: 64'(req_a[32*j +: 32]) * 64'(req_b[32*j +: 32]),
                        cyc: cyc});
        end
      end
    end
  end

  initial begin
    // Reset: ready forced low even with all requesters valid
    rst = 1'b1;
    req_valid = 4'hF;
    repeat (3) tick();
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(rsp_id), 64'd0);
    tick();
    rst = 1'b0;
    req_valid = '0;

    // 1: single max*max op, busy across the whole flight
    tick();
    req_a[31:0] = 32'hFFFF_FFFF;
    req_b[31:0] = 32'hFFFF_FFFF;
    req_valid = 4'b0001;
    base = rsp_cnt;
    tick();
    req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("s1_busy_hi", 64'(busy), 64'd1);
    end
    @(negedge clk);
    check("s1_busy_lo", 64'(busy), 64'd0);
    check("s1_count", 64'(rsp_cnt - base), 64'd1);
    check("s1_p", last_p, 64'hFFFF_FFFE_0000_0001);
    check("s1_id", 64'(last_id), 64'd0);

    // 2: all four valid for 16 cycles, grants rotate 0..3
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef MUL_ARB_PERF_CNT_EN
    pi0 = perf_issue;
    ps0 = perf_stall;
`endif
    for (int k = 0; k < 4; k++) begin
      req_a[32*k +: 32] = $urandom();
      req_b[32*k +: 32] = $urandom();
    end
    base = rsp_cnt;
    mark_first = 1'b1;
    req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("s2_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      tick();
      req_a[32*(c%4) +: 32] = $urandom();
      req_b[32*(c%4) +: 32] = $urandom();
    end
    req_valid = '0;
    drain();
    @(negedge clk);
    check("s2_count", 64'(rsp_cnt - base), 64'd16);
    check("s2_no_gaps", 64'(last_rsp_cyc - first_rsp_cyc), 64'd15);
`ifdef MUL_ARB_PERF_CNT_EN
    check("s6_perf_issue", 64'(perf_issue - pi0), 64'd16);
    check("s6_perf_stall", 64'(perf_stall - ps0), 64'd16);
`endif

    // 3: req2 alone moves rr_ptr to 3, req1 then wins by wrap; idle holds ptr
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a[95:64] = 32'h0001_2345;  req_b[95:64] = 32'h0000_0100;
    req_a[63:32] = 32'hDEAD_BEEF;  req_b[63:32] = 32'h0000_0003;
    req_a[31:0]  = 32'h0000_0007;  req_b[31:0]  = 32'h0000_0009;
    req_a[127:96] = 32'h1234_5678; req_b[127:96] = 32'h8765_4321;
    req_valid = 4'b0100;
    @(negedge clk);
    check("s3_g0", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b0110;
    @(negedge clk);
    check("s3_g1", 64'(req_ready), 64'h2);
    tick();
    @(negedge clk);
    check("s3_g2", 64'(req_ready), 64'h4);
    tick();
    @(negedge clk);
    check("s3_g3", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    req_valid = 4'b1001;
    @(negedge clk);
    check("s3_hold_g", 64'(req_ready), 64'h8);
    tick();
    @(negedge clk);
    check("s3_wrap_g", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    drain();

    // 4: three ops then a one-cycle reset drops them all
    tick();
    req_a[31:0] = 32'h0000_1111;
    req_b[31:0] = 32'h0000_2222;
    req_valid = 4'b0001;
    tick();
    tick();
    tick();
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    check("s4_ready_rst", 64'(req_ready), 64'd0);
    base = rsp_cnt;
    tick();
    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("s4_no_rsp", 64'(rsp_valid), 64'd0);
      check("s4_busy", 64'(busy), 64'd0);
    end
    check("s4_count", 64'(rsp_cnt - base), 64'd0);

    // 5: zero operand and 2^31*2 back-to-back from req3
    tick();
`ifdef MUL_ARB_PERF_CNT_EN
    ps0 = perf_stall;
`endif
    req_a[127:96] = 32'h0000_0000;
    req_b[127:96] = 32'd123;
    req_valid = 4'b1000;
    @(negedge clk);
    check("s5_g0", 64'(req_ready), 64'h8);
    tick();
    req_a[127:96] = 32'h8000_0000;
    req_b[127:96] = 32'd2;
    @(negedge clk);
    check("s5_g1", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    drain();
    @(negedge clk);
    check("s5_p", last_p, 64'h1_0000_0000);
    check("s5_id", 64'(last_id), 64'd3);
`ifdef MUL_ARB_PERF_CNT_EN
    check("s6_single_stall", 64'(perf_stall - ps0), 64'd0);
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
